// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU
// execute/memory stage and debug/monitor port) and the single-port memory.
//
// Handshake (both requester ports): a requester raises req together with
// we/end/dado and holds all four stable until the arbiter grants it. The
// arbiter samples the fields only at grant. Completion is the one-cycle ack
// pulse three cycles after grant; read data is in leitura from that same
// cycle. A req still high in the ack cycle is a fresh request that uses the
// fields presented in that cycle. Memory side: md_en/md_we/md_end/md_dado
// are driven by the arbiter; md_q is valid the cycle after md_en.
interface arbitro_memoria_dados_if #(
  parameter int LARGURA_DADOS = 16,
  parameter int LARGURA_END   = 16
);

  // CPU port
  logic                     cpu_req;
  logic                     cpu_we;
  logic [LARGURA_END-1:0]   cpu_end;
  logic [LARGURA_DADOS-1:0] cpu_dado;
  logic                     cpu_ack;
  logic [LARGURA_DADOS-1:0] cpu_leitura;
  logic                     cpu_stall;

  // Debug/monitor port
  logic                     dbg_req;
  logic                     dbg_we;
  logic [LARGURA_END-1:0]   dbg_end;
  logic [LARGURA_DADOS-1:0] dbg_dado;
  logic                     dbg_ack;
  logic [LARGURA_DADOS-1:0] dbg_leitura;

  // Memory port
  logic                     md_en;
  logic                     md_we;
  logic [LARGURA_END-1:0]   md_end;
  logic [LARGURA_DADOS-1:0] md_dado;
  logic [LARGURA_DADOS-1:0] md_q;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_end, cpu_dado,
    input  dbg_req, dbg_we, dbg_end, dbg_dado,
    input  md_q,
    output cpu_ack, cpu_leitura, cpu_stall,
    output dbg_ack, dbg_leitura,
    output md_en, md_we, md_end, md_dado
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_end, cpu_dado,
    output dbg_req, dbg_we, dbg_end, dbg_dado,
    output md_q,
    input  cpu_ack, cpu_leitura, cpu_stall,
    input  dbg_ack, dbg_leitura,
    input  md_en, md_we, md_end, md_dado
  );

endinterface

// File: rtl/arbitro_memoria_dados.sv
// Arbiter/sequencer for the shared single-port data memory. One access at a
// time runs through LIVRE -> ACESSO -> CAPTURA. The CPU has priority, but a
// starvation counter forces a debug grant after LIMITE_ESPERA consecutive
// CPU grants while debug is waiting. estado and contador are exposed for
// observation.
module arbitro_memoria_dados #(
  parameter int LARGURA_DADOS = 16,
  parameter int LARGURA_END   = 16,
  parameter int LIMITE_ESPERA = 4,
  parameter int LARGURA_CONT  = $clog2(LIMITE_ESPERA + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  arbitro_memoria_dados_if.slave  bus,
  output logic [1:0]              estado,
  output logic [LARGURA_CONT-1:0] contador
);

  typedef enum logic [1:0] {
    LIVRE   = 2'd0,
    ACESSO  = 2'd1,
    CAPTURA = 2'd2
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] LIMITE_C = LARGURA_CONT'(LIMITE_ESPERA);

  estado_t                  estado_q;
  logic [LARGURA_CONT-1:0]  contador_q;
  logic                     dono_q;      // 0 = CPU owns the access, 1 = debug
  logic                     we_q;        // latched write flag, kept through CAPTURA
  logic                     md_en_q;
  logic                     md_we_q;
  logic [LARGURA_END-1:0]   md_end_q;
  logic [LARGURA_DADOS-1:0] md_dado_q;
  logic                     cpu_ack_q;
  logic                     dbg_ack_q;
  logic [LARGURA_DADOS-1:0] cpu_leitura_q;
  logic [LARGURA_DADOS-1:0] dbg_leitura_q;

  logic ganha_dbg;
  logic ganha_cpu;

  // Priority decision on the current cycle's requests; only used in LIVRE.
  always_comb begin
    ganha_dbg = bus.dbg_req & (~bus.cpu_req | (contador_q == LIMITE_C));
    ganha_cpu = ~ganha_dbg & bus.cpu_req;
  end

  // Access sequencer: grant/latch in LIVRE, strobe memory in ACESSO,
  // capture read data and pulse the owner's ack in CAPTURA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= LIVRE;
      contador_q    <= '0;
      dono_q        <= 1'b0;
      we_q          <= 1'b0;
      md_en_q       <= 1'b0;
      md_we_q       <= 1'b0;
      md_end_q      <= '0;
      md_dado_q     <= '0;
      cpu_ack_q     <= 1'b0;
      dbg_ack_q     <= 1'b0;
      cpu_leitura_q <= '0;
      dbg_leitura_q <= '0;
    end else begin
      // Acks are single-cycle pulses.
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (estado_q)
        LIVRE: begin
          if (ganha_dbg) begin
            dono_q     <= 1'b1;
            we_q       <= bus.dbg_we;
            md_end_q   <= bus.dbg_end;
            md_dado_q  <= bus.dbg_dado;
            md_en_q    <= 1'b1;
            md_we_q    <= bus.dbg_we;
            contador_q <= '0;
            estado_q   <= ACESSO;
          end else if (ganha_cpu) begin
            dono_q    <= 1'b0;
            we_q      <= bus.cpu_we;
            md_end_q  <= bus.cpu_end;
            md_dado_q <= bus.cpu_dado;
            md_en_q   <= 1'b1;
            md_we_q   <= bus.cpu_we;
            // Count CPU grants that overtake a waiting debug request.
            if (bus.dbg_req) begin
              if (contador_q != LIMITE_C) begin
                contador_q <= contador_q + LARGURA_CONT'(1);
              end
            end else begin
              contador_q <= '0;
            end
            estado_q <= ACESSO;
          end else begin
            // Idle: nobody requesting, so debug is not waiting either.
            contador_q <= '0;
          end
        end
        ACESSO: begin
          md_en_q  <= 1'b0;
          md_we_q  <= 1'b0;
          estado_q <= CAPTURA;
        end
        CAPTURA: begin
          // md_q carries the word addressed during ACESSO; writes leave
          // both leitura registers untouched.
          if (!we_q) begin
            if (dono_q) begin
              dbg_leitura_q <= bus.md_q;
            end else begin
              cpu_leitura_q <= bus.md_q;
            end
          end
          if (dono_q) begin
            dbg_ack_q <= 1'b1;
          end else begin
            cpu_ack_q <= 1'b1;
          end
          estado_q <= LIVRE;
        end
        default: begin
          md_en_q  <= 1'b0;
          md_we_q  <= 1'b0;
          estado_q <= LIVRE;
        end
      endcase
    end
  end

  // Stall the pipeline while the CPU request is outstanding; it falls in
  // the ack cycle so the stage can advance with the read data.
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_ack_q;

  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_leitura = cpu_leitura_q;
  assign bus.dbg_ack     = dbg_ack_q;
  assign bus.dbg_leitura = dbg_leitura_q;
  assign bus.md_en       = md_en_q;
  assign bus.md_we       = md_we_q;
  assign bus.md_end      = md_end_q;
  assign bus.md_dado     = md_dado_q;

  assign estado   = estado_q;
  assign contador = contador_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: reset check, cycle-table vectors for
// single accesses, hand-written starvation and reset-mid-access sequences,
// then random traffic against a transaction-level reference model.
module tb_arbitro_memoria_dados;

  localparam int LD  = 16;
  localparam int LE  = 16;
  localparam int LIM = 4;
  localparam int LC  = $clog2(LIM + 1);
  localparam int N_RAND = 600;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    estado;
  logic [LC-1:0] contador;

  arbitro_memoria_dados_if #(.LARGURA_DADOS(LD), .LARGURA_END(LE)) bus ();

  arbitro_memoria_dados #(
    .LARGURA_DADOS(LD),
    .LARGURA_END  (LE),
    .LIMITE_ESPERA(LIM)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .estado  (estado),
    .contador(contador)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_init(input int i);
    case (i)
      'h10:    return 16'hBEEF;
      'h30:    return 16'h5A5A;
      'h40:    return 16'h0F0F;
      default: return 16'(i * 40503) ^ 16'h3C3C;
    endcase
  endfunction

  logic [15:0] mem [0:255];

  initial begin
    logic [15:0] q_next;
    for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
    bus.md_q <= '0;
    forever begin
      @(posedge clock);
      if (bus.md_en) begin
        q_next = mem[bus.md_end[7:0]];
        if (bus.md_we) mem[bus.md_end[7:0]] = bus.md_dado;
        bus.md_q <= q_next;
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic c_req; logic c_we; logic [15:0] c_end; logic [15:0] c_dado;
    logic d_req; logic d_we; logic [15:0] d_end; logic [15:0] d_dado;
    logic e_en;  logic e_we; logic [15:0] e_end; logic [15:0] e_dado;
    logic e_cack; logic e_dack; logic e_stall;
    logic [15:0] e_cl; logic [15:0] e_dl;
  } vec_t;

  task automatic drive_cpu(input logic req, input logic we, input logic [15:0] ende, input logic [15:0] dado);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_end = ende; bus.cpu_dado = dado;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [15:0] ende, input logic [15:0] dado);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_end = ende; bus.dbg_dado = dado;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".md_en"},       32'(bus.md_en),       32'(v.e_en));
    chk({tag, ".md_we"},       32'(bus.md_we),       32'(v.e_we));
    chk({tag, ".md_end"},      32'(bus.md_end),      32'(v.e_end));
    chk({tag, ".md_dado"},     32'(bus.md_dado),     32'(v.e_dado));
    chk({tag, ".cpu_ack"},     32'(bus.cpu_ack),     32'(v.e_cack));
    chk({tag, ".dbg_ack"},     32'(bus.dbg_ack),     32'(v.e_dack));
    chk({tag, ".cpu_stall"},   32'(bus.cpu_stall),   32'(v.e_stall));
    chk({tag, ".cpu_leitura"}, 32'(bus.cpu_leitura), 32'(v.e_cl));
    chk({tag, ".dbg_leitura"}, 32'(bus.dbg_leitura), 32'(v.e_dl));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- reference model state (random phase) ----------------
  logic [15:0] ref_mem [0:255];

  // ---------------- main test ----------------
  initial begin
    vec_t tab[$];
    bit   exp_cack, exp_dack, exp_en;
    // model
    int   free_at, en_at, ack_at, cnt;
    bit   m_own, m_we, win_d, win_c;
    logic [15:0] pend, exp_cl, exp_dl, exp_end, exp_dado;

    drive_cpu(0, 0, 16'h0, 16'h0);
    drive_dbg(0, 0, 16'h0, 16'h0);

    // ---- reset held with random inputs ----
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      drive_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      #1;
      check_vec("reset", '{bus.cpu_req, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
                           1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, bus.cpu_req, 16'h0, 16'h0});
      chk("reset.estado",   32'(estado),   32'd0);
      chk("reset.contador", 32'(contador), 32'd0);
    end
    @(negedge clock);
    drive_cpu(0, 0, 16'h0, 16'h0);
    drive_dbg(0, 0, 16'h0, 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      chk("idle.estado", 32'(estado),     32'd0);
      chk("idle.md_en",  32'(bus.md_en),  32'd0);
      chk("idle.ack",    32'({bus.cpu_ack, bus.dbg_ack}), 32'd0);
    end

    // ---- table-driven single-access vectors ----
    // CPU read of 0x0010 (0xBEEF)
    tab.push_back('{1,0,16'h0010,16'h0, 0,0,16'h0,16'h0,      0,0,16'h0000,16'h0000, 0,0,1, 16'h0000,16'h0000});
    tab.push_back('{1,0,16'h0010,16'h0, 0,0,16'h0,16'h0,      1,0,16'h0010,16'h0000, 0,0,1, 16'h0000,16'h0000});
    tab.push_back('{1,0,16'h0010,16'h0, 0,0,16'h0,16'h0,      0,0,16'h0010,16'h0000, 0,0,1, 16'h0000,16'h0000});
    tab.push_back('{0,0,16'h0010,16'h0, 0,0,16'h0,16'h0,      0,0,16'h0010,16'h0000, 1,0,0, 16'hBEEF,16'h0000});
    tab.push_back('{0,0,16'h0,16'h0,    0,0,16'h0,16'h0,      0,0,16'h0010,16'h0000, 0,0,0, 16'hBEEF,16'h0000});
    // Simultaneous: CPU reads 0x0040, debug reads 0x0030
    tab.push_back('{1,0,16'h0040,16'h0, 1,0,16'h0030,16'h0,   0,0,16'h0010,16'h0000, 0,0,1, 16'hBEEF,16'h0000});
    tab.push_back('{1,0,16'h0040,16'h0, 1,0,16'h0030,16'h0,   1,0,16'h0040,16'h0000, 0,0,1, 16'hBEEF,16'h0000});
    tab.push_back('{1,0,16'h0040,16'h0, 1,0,16'h0030,16'h0,   0,0,16'h0040,16'h0000, 0,0,1, 16'hBEEF,16'h0000});
    tab.push_back('{0,0,16'h0,16'h0,    1,0,16'h0030,16'h0,   0,0,16'h0040,16'h0000, 1,0,0, 16'h0F0F,16'h0000});
    tab.push_back('{0,0,16'h0,16'h0,    1,0,16'h0030,16'h0,   1,0,16'h0030,16'h0000, 0,0,0, 16'h0F0F,16'h0000});
    tab.push_back('{0,0,16'h0,16'h0,    1,0,16'h0030,16'h0,   0,0,16'h0030,16'h0000, 0,0,0, 16'h0F0F,16'h0000});
    tab.push_back('{0,0,16'h0,16'h0,    0,0,16'h0,16'h0,      0,0,16'h0030,16'h0000, 0,1,0, 16'h0F0F,16'h5A5A});
    tab.push_back('{0,0,16'h0,16'h0,    0,0,16'h0,16'h0,      0,0,16'h0030,16'h0000, 0,0,0, 16'h0F0F,16'h5A5A});
    // Debug writes 0x1234 to 0x0020, CPU then reads it back
    tab.push_back('{0,0,16'h0,16'h0,    1,1,16'h0020,16'h1234, 0,0,16'h0030,16'h0000, 0,0,0, 16'h0F0F,16'h5A5A});
    tab.push_back('{0,0,16'h0,16'h0,    1,1,16'h0020,16'h1234, 1,1,16'h0020,16'h1234, 0,0,0, 16'h0F0F,16'h5A5A});
    tab.push_back('{0,0,16'h0,16'h0,    1,1,16'h0020,16'h1234, 0,0,16'h0020,16'h1234, 0,0,0, 16'h0F0F,16'h5A5A});
    tab.push_back('{1,0,16'h0020,16'h0, 0,0,16'h0,16'h0,      0,0,16'h0020,16'h1234, 0,1,1, 16'h0F0F,16'h5A5A});
    tab.push_back('{1,0,16'h0020,16'h0, 0,0,16'h0,16'h0,      1,0,16'h0020,16'h0000, 0,0,1, 16'h0F0F,16'h5A5A});
    tab.push_back('{1,0,16'h0020,16'h0, 0,0,16'h0,16'h0,      0,0,16'h0020,16'h0000, 0,0,1, 16'h0F0F,16'h5A5A});
    tab.push_back('{0,0,16'h0,16'h0,    0,0,16'h0,16'h0,      0,0,16'h0020,16'h0000, 1,0,0, 16'h1234,16'h5A5A});
    tab.push_back('{0,0,16'h0,16'h0,    0,0,16'h0,16'h0,      0,0,16'h0020,16'h0000, 0,0,0, 16'h1234,16'h5A5A});

    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clock);
      drive_cpu(tab[i].c_req, tab[i].c_we, tab[i].c_end, tab[i].c_dado);
      drive_dbg(tab[i].d_req, tab[i].d_we, tab[i].d_end, tab[i].d_dado);
      #1;
      check_vec($sformatf("vec%0d", i), tab[i]);
    end

    // ---- starvation: CPU holds req, debug waits from cycle 0 ----
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k == 0) begin
        drive_cpu(1, 0, 16'h0050, 16'h0);
        drive_dbg(1, 0, 16'h0060, 16'h0);
      end
      if (k == 15) drive_dbg(0, 0, 16'h0, 16'h0);
      if (k == 18) drive_cpu(0, 0, 16'h0, 16'h0);
      #1;
      exp_cack = (k inside {3, 6, 9, 12, 18});
      exp_dack = (k == 15);
      exp_en   = (k inside {1, 4, 7, 10, 13, 16});
      chk($sformatf("starv%0d.cpu_ack", k), 32'(bus.cpu_ack), 32'(exp_cack));
      chk($sformatf("starv%0d.dbg_ack", k), 32'(bus.dbg_ack), 32'(exp_dack));
      chk($sformatf("starv%0d.md_en", k),   32'(bus.md_en),   32'(exp_en));
      if (exp_en) chk($sformatf("starv%0d.md_end", k), 32'(bus.md_end), (k == 13) ? 32'h60 : 32'h50);
      if (k == 4)  chk("starv.contador2", 32'(contador), 32'd2);
      if (k == 12) chk("starv.contador4", 32'(contador), 32'd4);
      if (k == 13) chk("starv.contador0", 32'(contador), 32'd0);
      if (k == 15) chk("starv.dbg_leitura", 32'(bus.dbg_leitura), 32'(mem_init('h60)));
      if (k == 18) chk("starv.cpu_leitura", 32'(bus.cpu_leitura), 32'(mem_init('h50)));
    end

    // ---- reset during ACESSO of a CPU read ----
    @(negedge clock);
    drive_cpu(1, 0, 16'h0010, 16'h0);
    drive_dbg(1, 0, 16'h0030, 16'h0);
    @(negedge clock); #1;
    chk("rstmid.pre_md_en",    32'(bus.md_en), 32'd1);
    chk("rstmid.pre_contador", 32'(contador),  32'd1);
    reset = 1'b0;
    drive_dbg(0, 0, 16'h0, 16'h0);
    #1;
    chk("rstmid.md_en",    32'(bus.md_en),   32'd0);
    chk("rstmid.md_we",    32'(bus.md_we),   32'd0);
    chk("rstmid.estado",   32'(estado),      32'd0);
    chk("rstmid.contador", 32'(contador),    32'd0);
    chk("rstmid.cpu_ack",  32'(bus.cpu_ack), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); #1;
      chk("rstmid.hold_ack",   32'(bus.cpu_ack), 32'd0);
      chk("rstmid.hold_md_en", 32'(bus.md_en),   32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clock); #1;
      chk($sformatf("rstmid.after%0d.cpu_ack", j), 32'(bus.cpu_ack), 32'(j == 3));
      chk($sformatf("rstmid.after%0d.md_en", j),   32'(bus.md_en),   32'(j == 1));
      if (j == 1) chk("rstmid.md_end", 32'(bus.md_end), 32'h10);
      if (j == 3) begin
        chk("rstmid.cpu_leitura", 32'(bus.cpu_leitura), 32'hBEEF);
        drive_cpu(0, 0, 16'h0, 16'h0);
      end
    end

    // ---- random traffic vs transaction-level model ----
    @(negedge clock);
    reset = 1'b0;
    drive_cpu(0, 0, 16'h0, 16'h0);
    drive_dbg(0, 0, 16'h0, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    free_at = 0; en_at = -1; ack_at = -1; cnt = 0;
    m_own = 0; m_we = 0; pend = '0;
    exp_cl = '0; exp_dl = '0; exp_end = '0; exp_dado = '0;

    for (int k = 0; k < N_RAND; k++) begin
      @(negedge clock);
      // Expected outputs for this cycle.
      if (k == ack_at && !m_we) begin
        if (m_own) exp_dl = pend;
        else       exp_cl = pend;
      end
      exp_cack = (k == ack_at) && !m_own;
      exp_dack = (k == ack_at) && m_own;
      exp_en   = (k == en_at);
      chk("rnd.md_en",       32'(bus.md_en),       32'(exp_en));
      chk("rnd.md_we",       32'(bus.md_we),       32'(exp_en && m_we));
      chk("rnd.md_end",      32'(bus.md_end),      32'(exp_end));
      chk("rnd.md_dado",     32'(bus.md_dado),     32'(exp_dado));
      chk("rnd.cpu_ack",     32'(bus.cpu_ack),     32'(exp_cack));
      chk("rnd.dbg_ack",     32'(bus.dbg_ack),     32'(exp_dack));
      chk("rnd.cpu_leitura", 32'(bus.cpu_leitura), 32'(exp_cl));
      chk("rnd.dbg_leitura", 32'(bus.dbg_leitura), 32'(exp_dl));
      chk("rnd.contador",    32'(contador),        32'(cnt));

      // Requesters: fields change only when idle or in their ack cycle.
      if (bus.cpu_req ? exp_cack : 1'b1) begin
        if ((bus.cpu_req && $urandom_range(0, 3) != 0) || (!bus.cpu_req && $urandom_range(0, 2) == 0))
          drive_cpu(1, 1'($urandom_range(0, 1)), 16'h0080 + 16'($urandom_range(0, 15)), 16'($urandom));
        else
          drive_cpu(0, 0, 16'h0, 16'h0);
      end
      if (bus.dbg_req ? exp_dack : 1'b1) begin
        if ((bus.dbg_req && $urandom_range(0, 3) == 0) || (!bus.dbg_req && $urandom_range(0, 2) == 0))
          drive_dbg(1, 1'($urandom_range(0, 1)), 16'h0080 + 16'($urandom_range(0, 15)), 16'($urandom));
        else
          drive_dbg(0, 0, 16'h0, 16'h0);
      end
      #1;
      chk("rnd.cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !exp_cack));

      // Arbitration on this cycle's requests when the memory is free.
      if (k >= free_at) begin
        win_d = bus.dbg_req && (!bus.cpu_req || cnt == LIM);
        win_c = !win_d && bus.cpu_req;
        if (win_d || win_c) begin
          m_own    = win_d;
          m_we     = win_d ? bus.dbg_we : bus.cpu_we;
          exp_end  = win_d ? bus.dbg_end : bus.cpu_end;
          exp_dado = win_d ? bus.dbg_dado : bus.cpu_dado;
          if (m_we) ref_mem[exp_end[7:0]] = exp_dado;
          else      pend = ref_mem[exp_end[7:0]];
          en_at   = k + 1;
          ack_at  = k + 3;
          free_at = k + 3;
          if (win_d)             cnt = 0;
          else if (bus.dbg_req)  cnt = (cnt < LIM) ? cnt + 1 : LIM;
          else                   cnt = 0;
        end else begin
          cnt = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
